cache_request_responder: RTL and testbench
==========================================

Name: cache_request_responder

Overview:
- Cache-side responder for the CPU-to-cache request channel. It receives CACHE_ADDR/CACHE_WR/CACHE_RD/CACHE_IN_DATA/CACHE_BVAL from the CPU-side bridge and answers with CACHE_OUT_DATA plus a one-cycle CACHE_ACK.
- Internally it is a direct-mapped, write-through, no-write-allocate cache of one-word lines.
- Misses and all writes go to a next-level memory over a level/ack handshake.
- It sits entirely in the cache clock domain.

Parameters:
- ADDR_W, 16, byte address width (matches c_ADDR_SIZE).
- DATA_W, 32, word width (matches c_CPU_DATA_SIZE).
- BVAL_W, 4, byte-enable width, DATA_W/8 (matches c_B_VAL_SIZE).
- IDX_W, 4, index bits; 2**IDX_W lines.

Ports:
- CACHE_CLK  in  1  sole clock; all logic on its rising edge.
- CACHE_RESET  in  1  synchronous, active-high reset.
- CACHE_ADDR  in  ADDR_W  request byte address.
- CACHE_WR  in  1  write request level, held until ACK is seen.
- CACHE_RD  in  1  read request level, held until ACK is seen.
- CACHE_IN_DATA  in  DATA_W  write data.
- CACHE_BVAL  in  BVAL_W  byte enables for writes; bit i covers byte i.
- CACHE_OUT_DATA  out  DATA_W  response data, valid while CACHE_ACK=1.
- CACHE_ACK  out  1  one-cycle completion pulse.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_RD  out  1  memory read level, held until MEM_ACK.
- MEM_WR  out  1  memory write level, held until MEM_ACK.
- MEM_OUT_DATA  out  DATA_W  memory write data.
- MEM_BVAL  out  BVAL_W  memory byte enables.
- MEM_IN_DATA  in  DATA_W  memory read data, valid with MEM_ACK.
- MEM_ACK  in  1  one-cycle memory completion pulse.
- HIT_CNT  out  16  saturating read-hit counter.
- MISS_CNT  out  16  saturating read-miss counter.

Behaviour:
- Address split: offset = low log2(BVAL_W) bits, ignored. Index = next IDX_W bits. Tag = remaining upper bits.
- Storage per line: valid bit, tag, DATA_W data.
- Reset: every output is 0 at the first edge with CACHE_RESET=1. All valid bits are cleared, the counters are cleared, and state returns to IDLE. Reset mid-operation abandons the request with no ACK. A stale MEM_ACK arriving after reset is ignored.
- FSM states: IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESP.
- IDLE: when CACHE_RD or CACHE_WR is 1 at an edge, latch addr/data/bval/op and go to LOOKUP. If both are 1, the request is a write.
- LOOKUP (one cycle): hit = valid[idx] && tag[idx]==req_tag.
  - Read hit -> RESP with line data; HIT_CNT+1.
  - Read miss -> MEM_READ; MISS_CNT+1.
  - Write -> MEM_WRITE. On a write hit, the line is byte-merged per BVAL in this cycle.
  - A write miss does not allocate and does not touch the counters.
- MEM_READ: MEM_RD=1 and MEM_ADDR=req addr, held until MEM_ACK. On the MEM_ACK edge: fill the line (valid=1, tag, data), capture MEM_IN_DATA, go to RESP, drop MEM_RD.
- MEM_WRITE: MEM_WR=1 with MEM_ADDR, MEM_OUT_DATA=req data and MEM_BVAL=req bval, held until MEM_ACK. On the MEM_ACK edge go to RESP and drop MEM_WR.
- RESP: CACHE_ACK=1 for exactly one cycle.
  - Reads: CACHE_OUT_DATA = the word.
  - Writes: CACHE_OUT_DATA echoes the write data.
  - Next state is IDLE unconditionally. Request levels seen during RESP are ignored, since the bridge drops them on the edge where it samples ACK.
- CACHE_OUT_DATA holds its last value when ACK=0. It is 0 only after reset.
- Latency, counting from the edge where IDLE latches the request:
  - Read hit: ACK in the 2nd following cycle.
  - Miss or write: 2 + (cycles until MEM_ACK).
- MEM_ACK outside MEM_READ/MEM_WRITE is ignored.
- MEM_RD and MEM_WR are never both 1.
- Counters saturate at 16'hFFFF; no wrap.
- A write hit updates data only. The valid and tag bits are unchanged.

Decomposition:
- Shared package/header (alongside Constants.vh):
  - state encoding (IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESP);
  - localparams for tag width (ADDR_W-IDX_W-log2(BVAL_W)) and offset width;
  - the byte-merge function.
- One sub-module: cache_line_store. It holds the valid/tag/data arrays with synchronous read, a write port with a byte-merge enable, and a synchronous clear of all valid bits.

Test Plan:
- Reset, then RD at 0x0010 -> miss. Sequence: MEM_RD=1 with MEM_ADDR=0x0010; memory acks with 0xDEADBEEF; one-cycle CACHE_ACK with OUT_DATA=0xDEADBEEF; MISS_CNT=1.
- Repeat RD 0x0010 -> ACK exactly 2 cycles after the latch edge, OUT=0xDEADBEEF, MEM_RD stays 0, HIT_CNT=1.
- WR 0x0010 data=0x000000AA BVAL=4'b0001 -> MEM_WR with MEM_BVAL=0001, then ACK. A following RD 0x0010 hits and returns 0xDEADBEAA.
- WR miss to 0x0050, then RD 0x0050 -> the read misses (no allocate), MISS_CNT increments, and MEM_RD is issued.
- RD 0x0110, same index as 0x0010 but a different tag -> miss and refill. A subsequent RD 0x0010 misses again.
- Assert CACHE_RESET while in MEM_READ -> MEM_RD=0 and no CACHE_ACK; a later MEM_ACK is ignored; RD 0x0010 then misses (valid bits cleared). Also check RD and WR asserted together are treated as a write.

Source files
------------

// File: rtl/cache_request_responder_pkg.sv
// Shared definitions for the cache request responder.
// Holds the geometry constants, the FSM state encoding and the byte-merge helper.
// This package has no ports.
package cache_request_responder_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BVAL_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned OFF_W  = $clog2(BVAL_W);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINES  = 2 ** IDX_W;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_MEM_READ  = 3'd2;
    localparam logic [2:0] ST_MEM_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    // Replace each byte of old_w whose enable bit is set with the same byte of new_w.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BVAL_W-1:0] bval
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < BVAL_W; i++) begin
            if (bval[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays.
// Ports: clk_i, clr_i (sync clear of all valid bits and read regs),
//        rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o (registered, one-cycle read),
//        wr_en_i/wr_merge_i/wr_idx_i/wr_tag_i/wr_data_i/wr_bval_i (fill or byte-merge).
module cache_line_store
    import cache_request_responder_pkg::*;
(
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic              wr_merge_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [BVAL_W-1:0] wr_bval_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Tag and data arrays need no reset: valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q    <= '0;
            rd_valid_o <= 1'b0;
            rd_tag_o   <= '0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= valid_q[rd_idx_i];
            rd_tag_o   <= tag_q[rd_idx_i];
            rd_data_o  <= data_q[rd_idx_i];
            if (wr_en_i) begin
                if (wr_merge_i) begin
                    // Write hit: data only, valid/tag stay as they are.
                    data_q[wr_idx_i] <= byte_merge(data_q[wr_idx_i], wr_data_i, wr_bval_i);
                end else begin
                    valid_q[wr_idx_i] <= 1'b1;
                    tag_q[wr_idx_i]   <= wr_tag_i;
                    data_q[wr_idx_i]  <= wr_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/cache_request_responder.sv
// Cache-side responder: direct-mapped, write-through, no-write-allocate cache of
// one-word lines answering CPU requests with a one-cycle CACHE_ACK.
// Ports: CACHE_CLK/CACHE_RESET; CPU side CACHE_ADDR/WR/RD/IN_DATA/BVAL -> CACHE_OUT_DATA/ACK;
//        memory side MEM_ADDR/RD/WR/OUT_DATA/BVAL <- MEM_IN_DATA/ACK; HIT_CNT/MISS_CNT stats.
module cache_request_responder
    import cache_request_responder_pkg::*;
(
    input  logic              CACHE_CLK,
    input  logic              CACHE_RESET,
    input  logic [ADDR_W-1:0] CACHE_ADDR,
    input  logic              CACHE_WR,
    input  logic              CACHE_RD,
    input  logic [DATA_W-1:0] CACHE_IN_DATA,
    input  logic [BVAL_W-1:0] CACHE_BVAL,
    output logic [DATA_W-1:0] CACHE_OUT_DATA,
    output logic              CACHE_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [DATA_W-1:0] MEM_OUT_DATA,
    output logic [BVAL_W-1:0] MEM_BVAL,
    input  logic [DATA_W-1:0] MEM_IN_DATA,
    input  logic              MEM_ACK,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  MISS_CNT
);

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [BVAL_W-1:0] req_bval_q, req_bval_d;
    logic              req_wr_q,   req_wr_d;
    logic              ack_q,      ack_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              mem_wr_q,   mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [BVAL_W-1:0] mem_bval_q, mem_bval_d;
    logic [CNT_W-1:0]  hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic              st_wr_en, st_wr_merge;
    logic [DATA_W-1:0] st_wr_data;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;

    // Reading with the live address means the line is ready in LOOKUP after the latch edge.
    cache_line_store u_store (
        .clk_i      (CACHE_CLK),
        .clr_i      (CACHE_RESET),
        .rd_idx_i   (CACHE_ADDR[OFF_W +: IDX_W]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (st_wr_en),
        .wr_merge_i (st_wr_merge),
        .wr_idx_i   (req_addr_q[OFF_W +: IDX_W]),
        .wr_tag_i   (req_addr_q[ADDR_W-1 -: TAG_W]),
        .wr_data_i  (st_wr_data),
        .wr_bval_i  (req_bval_q)
    );

    assign hit = rd_valid && (rd_tag == req_addr_q[ADDR_W-1 -: TAG_W]);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_bval_d  = req_bval_q;
        req_wr_d    = req_wr_q;
        ack_d       = 1'b0;
        out_data_d  = out_data_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_bval_d  = mem_bval_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        st_wr_en    = 1'b0;
        st_wr_merge = 1'b0;
        st_wr_data  = req_data_q;

        case (state_q)
            ST_IDLE: begin
                if (CACHE_RD || CACHE_WR) begin
                    req_addr_d = CACHE_ADDR;
                    req_data_d = CACHE_IN_DATA;
                    req_bval_d = CACHE_BVAL;
                    req_wr_d   = CACHE_WR;   // write wins when both levels are high
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (req_wr_q) begin
                    st_wr_en    = hit;
                    st_wr_merge = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = req_addr_q;
                    mem_data_d  = req_data_q;
                    mem_bval_d  = req_bval_q;
                    state_d     = ST_MEM_WRITE;
                end else if (hit) begin
                    ack_d      = 1'b1;
                    out_data_d = rd_data;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d    = ST_RESP;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr_q;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d    = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                if (MEM_ACK) begin
                    st_wr_en   = 1'b1;
                    st_wr_data = MEM_IN_DATA;
                    mem_rd_d   = 1'b0;
                    ack_d      = 1'b1;
                    out_data_d = MEM_IN_DATA;
                    state_d    = ST_RESP;
                end
            end
            ST_MEM_WRITE: begin
                if (MEM_ACK) begin
                    mem_wr_d   = 1'b0;
                    ack_d      = 1'b1;
                    out_data_d = req_data_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CACHE_CLK) begin
        if (CACHE_RESET) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_bval_q <= '0;
            req_wr_q   <= 1'b0;
            ack_q      <= 1'b0;
            out_data_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_bval_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_bval_q <= req_bval_d;
            req_wr_q   <= req_wr_d;
            ack_q      <= ack_d;
            out_data_q <= out_data_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_bval_q <= mem_bval_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign CACHE_ACK      = ack_q;
    assign CACHE_OUT_DATA = out_data_q;
    assign MEM_RD         = mem_rd_q;
    assign MEM_WR         = mem_wr_q;
    assign MEM_ADDR       = mem_addr_q;
    assign MEM_OUT_DATA   = mem_data_q;
    assign MEM_BVAL       = mem_bval_q;
    assign HIT_CNT        = hit_cnt_q;
    assign MISS_CNT       = miss_cnt_q;

endmodule

// File: tb/tb_cache_request_responder.sv
// Self-checking bench for cache_request_responder: a table of directed requests with
// hand-computed responses, plus a reset-during-MEM_READ sequence.
module tb_cache_request_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        wr, rd;
    logic [31:0] in_data;
    logic [3:0]  bval;
    logic [31:0] out_data;
    logic        ack;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_out_data;
    logic [3:0]  mem_bval;
    logic [31:0] mem_in_data;
    logic        mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_request_responder dut (
        .CACHE_CLK      (clk),
        .CACHE_RESET    (rst),
        .CACHE_ADDR     (addr),
        .CACHE_WR       (wr),
        .CACHE_RD       (rd),
        .CACHE_IN_DATA  (in_data),
        .CACHE_BVAL     (bval),
        .CACHE_OUT_DATA (out_data),
        .CACHE_ACK      (ack),
        .MEM_ADDR       (mem_addr),
        .MEM_RD         (mem_rd),
        .MEM_WR         (mem_wr),
        .MEM_OUT_DATA   (mem_out_data),
        .MEM_BVAL       (mem_bval),
        .MEM_IN_DATA    (mem_in_data),
        .MEM_ACK        (mem_ack),
        .HIT_CNT        (hit_cnt),
        .MISS_CNT       (miss_cnt)
    );

    // exp_mem: 0 = no memory access, 1 = memory read, 2 = memory write
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
        logic [31:0] mdata;
        int          dly;
        int          exp_mem;
        logic [31:0] exp_out;
        logic [15:0] exp_hit;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (req %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Issue one request, play the memory side, and check the response.
    task automatic run_req(input int idx, input vec_t v);
        int          cyc, lat, mem_seen;
        logic        got_ack, saw_rd, saw_wr, both;
        logic [31:0] got_out, m_data;
        logic [15:0] m_addr;
        logic [3:0]  m_bval;
        cyc = 0; lat = 0; mem_seen = 0;
        got_ack = 0; saw_rd = 0; saw_wr = 0; both = 0;
        got_out = '0; m_data = '0; m_addr = '0; m_bval = '0;
        @(negedge clk);
        rd = v.rd; wr = v.wr; addr = v.addr; in_data = v.wdata; bval = v.bval;
        @(posedge clk);
        while (!got_ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (mem_rd && mem_wr) both = 1'b1;
            if (ack) begin
                got_ack = 1'b1;
                lat     = cyc;
                got_out = out_data;
            end else if (mem_rd || mem_wr) begin
                if (mem_seen == 0) begin
                    saw_rd = mem_rd; saw_wr = mem_wr;
                    m_addr = mem_addr; m_data = mem_out_data; m_bval = mem_bval;
                end
                mem_seen++;
                if (mem_seen == v.dly + 1) begin
                    mem_ack     = 1'b1;
                    mem_in_data = v.mdata;
                end
            end
        end
        rd = 1'b0; wr = 1'b0; mem_ack = 1'b0;
        chk("ack_seen", idx, 32'(got_ack), 32'd1);
        chk("latency", idx, 32'(lat), (v.exp_mem == 0) ? 32'd2 : 32'(3 + v.dly));
        chk("out_data", idx, got_out, v.exp_out);
        chk("mem_rd_issued", idx, 32'(saw_rd), 32'(v.exp_mem == 1));
        chk("mem_wr_issued", idx, 32'(saw_wr), 32'(v.exp_mem == 2));
        chk("mem_rd_wr_both", idx, 32'(both), 32'd0);
        if (v.exp_mem != 0) chk("mem_addr", idx, 32'(m_addr), 32'(v.addr));
        if (v.exp_mem == 2) begin
            chk("mem_bval", idx, 32'(m_bval), 32'(v.bval));
            chk("mem_out_data", idx, m_data, v.wdata);
        end
        chk("hit_cnt", idx, 32'(hit_cnt), 32'(v.exp_hit));
        chk("miss_cnt", idx, 32'(miss_cnt), 32'(v.exp_miss));
        @(negedge clk);
        chk("ack_one_cycle", idx, 32'(ack), 32'd0);
        chk("out_hold", idx, out_data, v.exp_out);
    endtask

    initial begin
        logic stray;
        logic found;
        vec_t v;

        // All lines in this test land on index 4 except 0x0020 (index 8).
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 16'd0, 16'd1};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 16'd1, 16'd1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0010, 32'h000000AA, 4'h1, 32'h0,        2, 2, 32'h000000AA, 16'd1, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEAA, 16'd2, 16'd1};
        vecs[4]  = '{1'b0, 1'b1, 16'h0050, 32'h12345678, 4'hF, 32'h0,        0, 2, 32'h12345678, 16'd2, 16'd1};
        vecs[5]  = '{1'b1, 1'b0, 16'h0050, 32'h0,        4'h0, 32'hCAFEF00D, 3, 1, 32'hCAFEF00D, 16'd2, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 16'h0110, 32'h0,        4'h0, 32'h11112222, 0, 1, 32'h11112222, 16'd2, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 16'h0110, 32'h0,        4'h0, 32'h0,        0, 0, 32'h11112222, 16'd3, 16'd3};
        vecs[8]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 16'd3, 16'd4};
        vecs[9]  = '{1'b0, 1'b1, 16'h0010, 32'hAABBCCDD, 4'hA, 32'h0,        1, 2, 32'hAABBCCDD, 16'd3, 16'd4};
        vecs[10] = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'hAAADCC0D, 16'd4, 16'd4};
        vecs[11] = '{1'b1, 1'b1, 16'h0020, 32'h55AA55AA, 4'hC, 32'h0,        0, 2, 32'h55AA55AA, 16'd4, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 16'h0020, 32'h0,        4'h0, 32'h77777777, 2, 1, 32'h77777777, 16'd4, 16'd5};

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; in_data = '0; bval = '0;
        mem_in_data = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", -1, 32'(ack), 32'd0);
        chk("rst_out", -1, out_data, 32'd0);
        chk("rst_mem_rd_wr", -1, 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_mem_addr", -1, 32'(mem_addr), 32'd0);
        chk("rst_counts", -1, {hit_cnt, miss_cnt}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_req(i, vecs[i]);

        // Reset while a miss is waiting on memory: request is abandoned, state cleared.
        @(negedge clk);
        rd = 1'b1; addr = 16'h0030;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_rd) found = 1'b1;
        end
        chk("rst_seq_mem_rd", 100, 32'(found), 32'd1);
        rst = 1'b1; rd = 1'b0;
        @(negedge clk);
        chk("rst_seq_mem_rd_drop", 100, 32'(mem_rd), 32'd0);
        chk("rst_seq_ack", 100, 32'(ack), 32'd0);
        chk("rst_seq_out", 100, out_data, 32'd0);
        chk("rst_seq_counts", 100, {hit_cnt, miss_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_in_data = 32'hFEEDFACE;
        @(negedge clk);
        mem_ack = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack || mem_rd || mem_wr) stray = 1'b1;
        end
        chk("rst_seq_stale_mem_ack", 100, 32'(stray), 32'd0);

        // 0x0010 was valid before reset; it must miss now.
        v = '{1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'h31415926, 2, 1, 32'h31415926, 16'd0, 16'd1};
        run_req(101, v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
